// File: rtl/wb_arbiter_if.sv
// Write-back arbiter bus: two result producers in, one register-file write port
// and pending-write query ports out.
interface wb_arbiter_if #(
  parameter int BUS_WIDTH   = 64,
  parameter int REGFILE_LEN = 6,
  parameter int FIFO_DEPTH  = 4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                   a_valid, a_ready;
  logic [REGFILE_LEN-1:0] a_addr;
  logic [BUS_WIDTH-1:0]   a_data;
  logic                   b_valid, b_ready;
  logic [REGFILE_LEN-1:0] b_addr;
  logic [BUS_WIDTH-1:0]   b_data;
  logic                   wr_en;
  logic [REGFILE_LEN-1:0] wr_addr;
  logic [BUS_WIDTH-1:0]   wr_data;
  logic [REGFILE_LEN-1:0] q_addr1, q_addr2;
  logic                   q_pending1, q_pending2;
  logic [CW-1:0]          fifo_count;

  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data, q_addr1, q_addr2,
    output a_ready, b_ready, wr_en, wr_addr, wr_data, q_pending1, q_pending2, fifo_count
  );

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data, q_addr1, q_addr2,
    input  a_ready, b_ready, wr_en, wr_addr, wr_data, q_pending1, q_pending2, fifo_count
  );
endinterface

// File: rtl/wb_arbiter.sv
// Register-file write-back arbiter: unbuffered high-priority A channel, in-order
// FIFO for the long-latency B channel, starvation guard and WAW ordering.
module wb_arbiter #(
  parameter int BUS_WIDTH    = 64,
  parameter int REGFILE_LEN  = 6,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic          clk,
  input  logic          rst,
  wb_arbiter_if.slave   bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int AW = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [REGFILE_LEN-1:0] addr;
    logic [BUS_WIDTH-1:0]   data;
  } wb_ent_t;

  wb_ent_t                mem_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]  vld_q, vld_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [AW-1:0]          age_q, age_d;
  logic                   wr_en_q, wr_en_d;
  logic [REGFILE_LEN-1:0] wr_addr_q, wr_addr_d;
  logic [BUS_WIDTH-1:0]   wr_data_q, wr_data_d;

  logic                   empty, full, a_conflict, fifo_grant, a_ready, b_ready;
  logic                   enq, a_acc;
  logic [FIFO_DEPTH-1:0]  hit_a, hit_q1, hit_q2;
  wb_ent_t                head;

  // Per-entry address comparators; only occupied slots participate.
  for (genvar i = 0; i < FIFO_DEPTH; i++) begin : g_match
    assign hit_a[i]  = vld_q[i] && (mem_q[i].addr == bus.a_addr);
    assign hit_q1[i] = vld_q[i] && (mem_q[i].addr == bus.q_addr1);
    assign hit_q2[i] = vld_q[i] && (mem_q[i].addr == bus.q_addr2);
  end

  assign empty      = (cnt_q == '0);
  assign full       = (cnt_q == CW'(FIFO_DEPTH));
  assign head       = mem_q[rd_ptr_q];
  assign a_conflict = bus.a_valid && (bus.a_addr != '0) && (|hit_a);
  assign fifo_grant = !empty && (!bus.a_valid || full || (age_q >= AW'(STARVE_LIMIT)) || a_conflict);
  assign a_ready    = !rst && !fifo_grant && !a_conflict;
  assign b_ready    = !rst && !full;
  assign enq        = bus.b_valid && b_ready;
  assign a_acc      = bus.a_valid && a_ready;

  always_comb begin
    vld_d    = vld_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    // enq and deq never target the same slot: that needs rd==wr, i.e. empty or full.
    if (fifo_grant) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + PW'(1);
    end
    if (enq) begin
      vld_d[wr_ptr_q] = 1'b1;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    case ({enq, fifo_grant})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    age_d = age_q;
    if (empty || fifo_grant)
      age_d = '0;
    else if (a_acc && (age_q < AW'(STARVE_LIMIT)))
      age_d = age_q + AW'(1);
  end

  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (fifo_grant) begin
      wr_en_d   = (head.addr != '0);
      wr_addr_d = head.addr;
      wr_data_d = head.data;
    end else if (a_acc) begin
      wr_en_d   = (bus.a_addr != '0);
      wr_addr_d = bus.a_addr;
      wr_data_d = bus.a_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q     <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      cnt_q     <= '0;
      age_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      vld_q     <= vld_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      cnt_q     <= cnt_d;
      age_q     <= age_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Payload storage needs no reset: occupancy is tracked by vld_q.
  always_ff @(posedge clk) begin
    if (enq) mem_q[wr_ptr_q] <= '{addr: bus.b_addr, data: bus.b_data};
  end

  assign bus.a_ready    = a_ready;
  assign bus.b_ready    = b_ready;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.fifo_count = cnt_q;
  assign bus.q_pending1 = (bus.q_addr1 != '0) && ((|hit_q1) || (wr_en_q && wr_addr_q == bus.q_addr1));
  assign bus.q_pending2 = (bus.q_addr2 != '0) && ((|hit_q2) || (wr_en_q && wr_addr_q == bus.q_addr2));
endmodule
